// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32x32 GPR file plus HI/LO, fed by the MEM/WB writeback stage
// Optional same-cycle writeback-to-read bypass enabled by defining WB_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] gpr_q [NUM_REGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              gpr_we_d;
    logic              byp1_d;
    logic              byp2_d;
    logic              byp_hilo_d;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    assign gpr_we_d = wb_wreg && (wb_wd != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (gpr_we_d) begin
                gpr_q[wb_wd] <= wb_wdata;
            end
            if (wb_whilo) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign byp1_d     = gpr_we_d && (wb_wd == raddr1);
    assign byp2_d     = gpr_we_d && (wb_wd == raddr2);
    assign byp_hilo_d = wb_whilo;
`else
    assign byp1_d     = 1'b0;
    assign byp2_d     = 1'b0;
    assign byp_hilo_d = 1'b0;
`endif

    always_comb begin
        rdata1 = '0;
        if (resetn && re1 && (raddr1 != '0)) begin
            rdata1 = byp1_d ? wb_wdata : gpr_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (resetn && re2 && (raddr2 != '0)) begin
            rdata2 = byp2_d ? wb_wdata : gpr_q[raddr2];
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (resetn) begin
            hi_o = byp_hilo_d ? wb_hi : hi_q;
            lo_o = byp_hilo_d ? wb_lo : lo_q;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed and random checks of wb_regfile
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    wb_regfile dut (
        .clk      (clk),
        .resetn   (resetn),
        .wb_wreg  (wb_wreg),
        .wb_wd    (wb_wd),
        .wb_wdata (wb_wdata),
        .wb_whilo (wb_whilo),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_wreg  = 1'b0;
        wb_whilo = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'h0;
        if (BYP && wb_wreg && wb_wd == a) return wb_wdata;
        return m_gpr[a];
    endfunction

    initial begin
        resetn = 1'b0;
        wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
        wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd1", rdata1, 32'h0);
        check("rst_hi", hi_o, 32'h0);
        next();
        resetn = 1'b1;

        // 1: reset pulsed mid-cycle clears state and blocks an in-flight write
        wb_wreg = 1'b1; wb_wd = 5'd1; wb_wdata = 32'd11;
        wb_whilo = 1'b1; wb_hi = 32'd33; wb_lo = 32'd44;
        next();
        wb_wd = 5'd2; wb_wdata = 32'd22; wb_whilo = 1'b0;
        next();
        idle();
        @(negedge clk);
        check("t1_pre_rd1", rdata1, 32'd11);
        check("t1_pre_rd2", rdata2, 32'd22);
        check("t1_pre_hi", hi_o, 32'd33);
        #2 resetn = 1'b0;
        #1;
        check("t1_rst_rd1", rdata1, 32'h0);
        check("t1_rst_rd2", rdata2, 32'h0);
        check("t1_rst_hi", hi_o, 32'h0);
        check("t1_rst_lo", lo_o, 32'h0);
        wb_wreg = 1'b1; wb_wd = 5'd1; wb_wdata = 32'd99;
        wb_whilo = 1'b1; wb_hi = 32'd55; wb_lo = 32'd66;
        #1;
        check("t1_rst_byp_rd1", rdata1, 32'h0);
        check("t1_rst_byp_hi", hi_o, 32'h0);
        next();
        idle();
        resetn = 1'b1;
        @(negedge clk);
        check("t1_post_rd1", rdata1, 32'h0);
        check("t1_post_rd2", rdata2, 32'h0);
        check("t1_post_hi", hi_o, 32'h0);
        check("t1_post_lo", lo_o, 32'h0);

        // 2: basic write then read, and read enable gating
        next();
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF;
        next();
        idle(); re1 = 1'b1; raddr1 = 5'd5;
        @(negedge clk);
        check("t2_rd1", rdata1, 32'hDEADBEEF);
        re1 = 1'b0;
        #1;
        check("t2_re_off", rdata1, 32'h0);

        // 3: writes to register 0 are discarded
        next();
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
        next();
        idle(); re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        @(negedge clk);
        check("t3_rd1_zero", rdata1, 32'h0);
        check("t3_rd2_zero", rdata2, 32'h0);

        // 4: same-cycle writeback bypass
        next();
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'd1;
        next();
        wb_wdata = 32'd2; raddr1 = 5'd7; raddr2 = 5'd5;
        @(negedge clk);
        check("t4_byp_rd1", rdata1, BYP ? 32'd2 : 32'd1);
        check("t4_nohit_rd2", rdata2, 32'hDEADBEEF);
        next();
        idle();
        @(negedge clk);
        check("t4_next_rd1", rdata1, 32'd2);

        // 5: HI/LO write alongside a GPR write
        next();
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h3; raddr1 = 5'd3;
        @(negedge clk);
        check("t5_byp_hi", hi_o, BYP ? 32'h1 : 32'h0);
        check("t5_byp_lo", lo_o, BYP ? 32'h2 : 32'h0);
        check("t5_byp_rd1", rdata1, BYP ? 32'h3 : 32'h0);
        next();
        idle(); wb_hi = 32'hFF; wb_lo = 32'hEE;
        @(negedge clk);
        check("t5_hi", hi_o, 32'h1);
        check("t5_lo", lo_o, 32'h2);
        check("t5_gpr3", rdata1, 32'h3);
        next();
        @(negedge clk);
        check("t5_hold_hi", hi_o, 32'h1);
        check("t5_hold_lo", lo_o, 32'h2);

        // 6: both ports on one address
        next();
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'hA5A5A5A5;
        next();
        idle(); raddr1 = 5'd9; raddr2 = 5'd9;
        @(negedge clk);
        check("t6_rd1", rdata1, 32'hA5A5A5A5);
        check("t6_rd2", rdata2, 32'hA5A5A5A5);

        // 6b: random traffic against a reference model
        next();
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        next();
        resetn = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            wb_wreg  = 1'($urandom_range(0, 1));
            wb_wd    = 5'($urandom_range(0, 31));
            wb_wdata = $urandom;
            wb_whilo = 1'($urandom_range(0, 1));
            wb_hi    = $urandom;
            wb_lo    = $urandom;
            re1      = ($urandom_range(0, 3) != 0);
            raddr1   = 5'($urandom_range(0, 31));
            re2      = ($urandom_range(0, 3) != 0);
            raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            @(negedge clk);
            check("rnd_rd1", rdata1, exp_rd(re1, raddr1));
            check("rnd_rd2", rdata2, exp_rd(re2, raddr2));
            check("rnd_hi", hi_o, (BYP && wb_whilo) ? wb_hi : m_hi);
            check("rnd_lo", lo_o, (BYP && wb_whilo) ? wb_lo : m_lo);
            @(posedge clk);
            if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
